// File: rtl/timer32_pkg.sv
// timer32 shared types: FSM encoding, default widths, reset value.
// DONE is only reachable when TIMER32_ONESHOT_EN is defined.
package timer32_pkg;

  localparam int TMR_W_DEF = 32;
  localparam int PRE_W_DEF = 32;

  localparam logic [31:0] TMR_RESET_VAL = 32'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/timer32_ctrl_if.sv
// Register-block <-> timer32_ctrl field bundle.
// TMRONESHOT exists only when TIMER32_ONESHOT_EN is defined.
import timer32_pkg::*;

interface timer32_ctrl_if #(
  parameter int TMR_W = TMR_W_DEF,
  parameter int PRE_W = PRE_W_DEF
);

  logic [PRE_W-1:0] PRE;
  logic [TMR_W-1:0] TMRCMP;
  logic             TMREN;
  logic             TMROVCLR;
`ifdef TIMER32_ONESHOT_EN
  logic             TMRONESHOT;
`endif
  logic [TMR_W-1:0] TMR;
  logic             TMROV;
  logic             TMRTICK;

  modport master (
    output PRE,
    output TMRCMP,
    output TMREN,
    output TMROVCLR,
`ifdef TIMER32_ONESHOT_EN
    output TMRONESHOT,
`endif
    input  TMR,
    input  TMROV,
    input  TMRTICK
  );

  modport slave (
    input  PRE,
    input  TMRCMP,
    input  TMREN,
    input  TMROVCLR,
`ifdef TIMER32_ONESHOT_EN
    input  TMRONESHOT,
`endif
    output TMR,
    output TMROV,
    output TMRTICK
  );

endinterface

// File: rtl/timer32_prescaler.sv
// Prescaler: free-running pcnt, tick when pcnt >= PRE.
// The >= keeps a mid-run PRE decrease from overrunning.
import timer32_pkg::*;

module timer32_prescaler #(
  parameter int PRE_W = PRE_W_DEF
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             clear,
  input  logic             run,
  input  logic [PRE_W-1:0] pre,
  output logic             tick
);

  logic [PRE_W-1:0] pcnt;

  assign tick = run && (pcnt >= pre);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      pcnt <= '0;
    end else if (clear) begin
      pcnt <= '0;
    end else if (run) begin
      pcnt <= tick ? '0 : pcnt + PRE_W'(1);
    end
  end

endmodule

// File: rtl/timer32_ctrl.sv
// TIMER32 counting engine: FSM, counter, sticky overflow, clear edge.
// Optional one-shot mode (DONE state): define TIMER32_ONESHOT_EN.
import timer32_pkg::*;

module timer32_ctrl #(
  parameter int TMR_W = TMR_W_DEF,
  parameter int PRE_W = PRE_W_DEF
) (
  input logic           PCLK,
  input logic           PRESET,
  timer32_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_LOAD = LOAD;
  localparam logic [1:0] ST_RUN  = RUN;
`ifdef TIMER32_ONESHOT_EN
  localparam logic [1:0] ST_DONE = DONE;
`endif

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [TMR_W-1:0] tmr_q;
  logic             ov_q;
  logic             tick_q;
  logic             clr_q;
  logic             run;
  logic             tick;
  logic             wrap;
  logic             clr_edge;

  assign run      = (state_q == ST_RUN) && bus.TMREN;
  assign wrap     = tick && (tmr_q >= bus.TMRCMP);
  assign clr_edge = bus.TMROVCLR && !clr_q;

  timer32_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .clear  (state_q == ST_LOAD),
    .run    (run),
    .pre    (bus.PRE),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.TMREN) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d = bus.TMREN ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        if (!bus.TMREN) state_d = ST_IDLE;
`ifdef TIMER32_ONESHOT_EN
        else if (wrap && bus.TMRONESHOT)
          state_d = ST_DONE;
`endif
      end
`ifdef TIMER32_ONESHOT_EN
      ST_DONE: begin
        if (!bus.TMREN) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= ST_IDLE;
      tmr_q   <= TMR_W'(TMR_RESET_VAL);
      ov_q    <= 1'b0;
      tick_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= bus.TMROVCLR;
      tick_q  <= tick;
      if (state_q == ST_LOAD) begin
        tmr_q <= TMR_W'(TMR_RESET_VAL);
      end else if (tick) begin
        tmr_q <= wrap ? '0 : tmr_q + TMR_W'(1);
      end
      // overflow set beats a coincident clear edge
      if (wrap) begin
        ov_q <= 1'b1;
      end else if (clr_edge) begin
        ov_q <= 1'b0;
      end
    end
  end

  assign bus.TMR     = tmr_q;
  assign bus.TMROV   = ov_q;
  assign bus.TMRTICK = tick_q;

endmodule

// File: tb/tb_timer32_ctrl.sv
// Scoreboard bench for timer32_ctrl: directed + random stimulus.
// Define TIMER32_ONESHOT_EN to also exercise one-shot mode.
import timer32_pkg::*;

module tb_timer32_ctrl;

  logic PCLK = 1'b1;
  logic PRESET;

  timer32_ctrl_if #(.TMR_W(32), .PRE_W(32)) bus ();

  timer32_ctrl #(
    .TMR_W (32),
    .PRE_W (32)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic [31:0] tmr;
    logic        ov;
    logic        tick;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_cyc    = 0;

  // reference model: what the timer is doing, not how
  localparam int M_OFF  = 0;
  localparam int M_ARM  = 1;
  localparam int M_CNT  = 2;
  localparam int M_HALT = 3;

  int          m_mode = M_OFF;
  logic [31:0] m_cnt  = 0;
  logic [31:0] m_wait = 0;
  bit          m_ov   = 0;
  bit          m_prev = 0;
  bit          m_tick = 0;

  bit          s_en  = 0;
  logic [31:0] s_pre = 0;
  logic [31:0] s_cmp = 0;
  bit          s_clr = 0;
  bit          s_os  = 0;

  task automatic model_step(bit rst, bit en, logic [31:0] pre,
                            logic [31:0] cmp, bit clr, bit os);
    bit overflow = 0;
    if (rst) begin
      m_mode = M_OFF;
      m_cnt  = 0;
      m_wait = 0;
      m_ov   = 0;
      m_prev = 0;
      m_tick = 0;
      return;
    end
    m_tick = 0;
    case (m_mode)
      M_OFF: if (en) m_mode = M_ARM;
      M_ARM: begin
        m_cnt  = 0;
        m_wait = 0;
        m_mode = en ? M_CNT : M_OFF;
      end
      M_CNT: begin
        if (!en) begin
          m_mode = M_OFF;
        end else if (m_wait >= pre) begin
          m_wait = 0;
          m_tick = 1;
          if (m_cnt >= cmp) begin
            m_cnt    = 0;
            overflow = 1;
            if (os) m_mode = M_HALT;
          end else begin
            m_cnt = m_cnt + 1;
          end
        end else begin
          m_wait = m_wait + 1;
        end
      end
      default: if (!en) m_mode = M_OFF;
    endcase
    if (overflow) m_ov = 1;
    else if (clr && !m_prev) m_ov = 0;
    m_prev = clr;
  endtask

  task automatic cyc(bit rst);
    bit os = s_os;
`ifndef TIMER32_ONESHOT_EN
    os = 0;
`endif
    @(negedge PCLK);
    PRESET       = rst;
    bus.TMREN    = s_en;
    bus.PRE      = s_pre;
    bus.TMRCMP   = s_cmp;
    bus.TMROVCLR = s_clr;
`ifdef TIMER32_ONESHOT_EN
    bus.TMRONESHOT = os;
`endif
    model_step(rst, s_en, s_pre, s_cmp, s_clr, os);
    q.push_back('{m_cnt, m_ov, m_tick});
  endtask

  task automatic step(int n);
    for (int i = 0; i < n; i++) cyc(1'b0);
  endtask

  // monitor: compare DUT outputs after every edge
  initial begin
    exp_t e;
    forever begin
      @(posedge PCLK);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        n_cyc++;
        n_checks++;
        if (bus.TMR !== e.tmr || bus.TMROV !== e.ov ||
            bus.TMRTICK !== e.tick) begin
          n_fail++;
          $display("FAIL outputs cyc%0d: TMR=%0d TMROV=%0b TICK=%0b, want %0d %0b %0b",
                   n_cyc, bus.TMR, bus.TMROV, bus.TMRTICK,
                   e.tmr, e.ov, e.tick);
        end
      end
    end
  end

  initial begin
    cyc(1'b1);
    cyc(1'b1);
    step(2);

    // basic periodic count, PRE=0
    s_pre = 0; s_cmp = 3; s_en = 1;
    step(8);

    // prescaled count, freeze, re-enable
    s_en = 0; step(2);
    s_pre = 2; s_cmp = 10; s_en = 1;
    for (int i = 0; i < 100 && m_cnt != 4; i++) step(1);
    s_en = 0; step(5);
    s_en = 1; step(8);

    // clear edge, held clear, coincident set
    s_pre = 0; s_cmp = 1;
    for (int i = 0; i < 50 && !m_ov; i++) step(1);
    s_clr = 1; step(4);
    step(4);
    s_clr = 0; step(1);
    for (int i = 0; i < 50 && m_cnt != s_cmp; i++) step(1);
    s_clr = 1; step(2);
    s_clr = 0; step(1);

    // TMRCMP lowered below TMR
    s_en = 0; step(1);
    s_pre = 0; s_cmp = 20; s_en = 1;
    for (int i = 0; i < 50 && m_cnt != 8; i++) step(1);
    s_cmp = 5; step(3);

    // PRE lowered mid-prescale
    s_en = 0; step(1);
    s_pre = 100; s_cmp = 1000; s_en = 1;
    step(52);
    s_pre = 1; step(4);

    // reset mid-run with TMR=7, TMROV=1, TMREN held
    s_pre = 0; s_cmp = 7;
    for (int i = 0; i < 50 && !(m_cnt == 7 && m_ov); i++) step(1);
    cyc(1'b1);
    step(4);

`ifdef TIMER32_ONESHOT_EN
    s_os = 1; s_en = 0; step(1);
    s_pre = 0; s_cmp = 2; s_en = 1;
    step(9);
    s_en = 0; step(1);
    s_en = 1; step(6);
    s_os = 0;
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 3) s_en = !s_en;
      if ($urandom_range(99) < 10) s_clr = !s_clr;
      if ($urandom_range(99) < 2) s_os = !s_os;
      if ($urandom_range(99) < 5)
        s_pre = ($urandom_range(9) == 0) ?
                32'($urandom_range(20)) : 32'($urandom_range(3));
      if ($urandom_range(99) < 5)
        s_cmp = 32'($urandom_range(12));
      cyc($urandom_range(199) == 0);
    end

    repeat (2) @(posedge PCLK);
    #2;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
